// File: rtl/adder_seq_pkg.sv
// Shared constants and state encoding for the slice-serial adder/subtractor.
package adder_seq_pkg;
    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/adder_sequencer_adder16_ci.sv
// One 16-bit adder slice with carry-in and carry-out.
module adder16_ci
    import adder_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);
    logic [SLICE_W:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, ci};
    assign s    = full[SLICE_W-1:0];
    assign co   = full[SLICE_W];
endmodule

// File: rtl/adder_sequencer.sv
// Slice-serial W-bit add/subtract: one 16-bit slice per cycle through a shared adder.
// Optional signed-overflow output V is enabled by defining ADDER_SEQ_OVF_EN.
module adder_sequencer
    import adder_seq_pkg::*;
#(
    parameter int SLICES = 4
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Run,
    input  logic                      Sub,
    input  logic [SLICE_W*SLICES-1:0] A,
    input  logic [SLICE_W*SLICES-1:0] B,
    output logic [SLICE_W*SLICES-1:0] Sum,
    output logic                      CO,
    output logic                      Done
`ifdef ADDER_SEQ_OVF_EN
    ,
    output logic                      V
`endif
);
    localparam int W     = SLICE_W * SLICES;
    localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(SLICES - 1);

    state_t             state, next_state;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic               sub_q;
    logic [W-1:0]       a_q, b_q, sum_q;
    logic               co_q;

    logic [SLICE_W-1:0] a_sl, b_sl, s_sl;
    logic               c_sl;

    // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
    assign a_sl = a_q[SLICE_W*idx +: SLICE_W];
    assign b_sl = b_q[SLICE_W*idx +: SLICE_W] ^ {SLICE_W{sub_q}};

    adder16_ci u_slice (
        .a  (a_sl),
        .b  (b_sl),
        .ci (carry),
        .s  (s_sl),
        .co (c_sl)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (Run) next_state = ADD;
            ADD:     if (idx == LAST) next_state = DONE;
            DONE:    if (!Run) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

`ifdef ADDER_SEQ_OVF_EN
    logic v_q;
    // Same-sign effective operands producing a different-sign result.
    wire  ovf = (a_sl[SLICE_W-1] == b_sl[SLICE_W-1]) && (s_sl[SLICE_W-1] != a_sl[SLICE_W-1]);

    always_ff @(posedge Clk) begin
        if (!Reset)
            v_q <= 1'b0;
        else if (state == IDLE && Run)
            v_q <= 1'b0;
        else if (state == ADD && idx == LAST)
            v_q <= ovf;
    end

    assign V = v_q;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            sub_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            co_q  <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: if (Run) begin
                    a_q   <= A;
                    b_q   <= B;
                    sub_q <= Sub;
                    sum_q <= '0;
                    co_q  <= 1'b0;
                    idx   <= '0;
                    carry <= Sub;
                end
                ADD: begin
                    sum_q[SLICE_W*idx +: SLICE_W] <= s_sl;
                    carry <= c_sl;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) co_q <= c_sl;
                end
                default: ;
            endcase
        end
    end

    assign Sum  = sum_q;
    assign CO   = co_q;
    assign Done = (state == DONE);
endmodule

// File: tb/tb_adder_sequencer.sv
// Self-checking bench for adder_sequencer (SLICES=4): directed table, corner sequences, random vs model.
module tb_adder_sequencer;
    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Run = 1'b0;
    logic        Sub = 1'b0;
    logic [63:0] A = '0;
    logic [63:0] B = '0;
    logic [63:0] Sum;
    logic        CO;
    logic        Done;
`ifdef ADDER_SEQ_OVF_EN
    logic        V;
`endif

    int passed = 0;
    int total  = 0;

    adder_sequencer #(.SLICES(4)) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .Run  (Run),
        .Sub  (Sub),
        .A    (A),
        .B    (B),
        .Sum  (Sum),
        .CO   (CO),
        .Done (Done)
`ifdef ADDER_SEQ_OVF_EN
        ,
        .V    (V)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic [63:0] sum;
        logic        co;
        logic        tog;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    // Start an operation and wait for Done; returns the latency in cycles after capture.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic sub,
                          input logic tog, input logic hold, output int lat);
        @(negedge Clk);
        A = a; B = b; Sub = sub; Run = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        if (!hold) Run = 1'b0;
        if (tog) begin
            A = $urandom(); B = ~b; Sub = ~sub;
        end
        lat = 0;
        while (1) begin
            @(posedge Clk);
            lat++;
            #1;
            if (tog) begin A = {$urandom(), $urandom()}; B = {$urandom(), $urandom()}; end
            if (Done || lat > 20) break;
        end
        if (lat > 20) chk("done_timeout", 64'(lat), 64'd4);
    endtask

    task automatic release_done();
        @(negedge Clk);
        Run = 1'b0;
        @(posedge Clk);
        #1;
        chk("done_clears", {63'd0, Done}, 64'd0);
    endtask

    task automatic model(input logic [63:0] a, input logic [63:0] b, input logic sub,
                         output logic [63:0] s, output logic co, output logic v);
        logic [64:0] t;
        if (sub) begin
            s  = a - b;
            co = (a >= b);
            v  = (a[63] != b[63]) && (s[63] != a[63]);
        end else begin
            t  = {1'b0, a} + {1'b0, b};
            s  = t[63:0];
            co = t[64];
            v  = (a[63] == b[63]) && (s[63] != a[63]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [63:0] es, held;
        logic        ec, ev;

        vt[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
        vt[2] = '{64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        vt[3] = '{64'h0000_0000_0001_0000, 64'h1, 1'b1, 64'h0000_0000_0000_FFFF, 1'b1, 1'b1};
        vt[4] = '{64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 1'b0, 64'h7777_7777_7777_7777, 1'b0, 1'b0};
        vt[5] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'h0, 1'b1, 1'b1};
        vt[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b0};
        vt[7] = '{64'h0001_0000_0000_0000, 64'h1, 1'b1, 64'h0000_FFFF_FFFF_FFFF, 1'b1, 1'b1};

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_sum", Sum, 64'h0);
        chk("rst_co", {63'd0, CO}, 64'd0);
        chk("rst_done", {63'd0, Done}, 64'd0);
        @(negedge Clk);
        Reset = 1'b1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].sub, vt[i].tog, 1'b0, lat);
            chk($sformatf("tab%0d_lat", i), 64'(lat), 64'd4);
            chk($sformatf("tab%0d_sum", i), Sum, vt[i].sum);
            chk($sformatf("tab%0d_co", i), {63'd0, CO}, {63'd0, vt[i].co});
            release_done();
            chk($sformatf("tab%0d_sum_idle", i), Sum, vt[i].sum);
        end

        // Run held after Done: no restart, result held
        run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 1'b1, lat);
        held = 64'h0000_0000_0001_0000;
        chk("hold_lat", 64'(lat), 64'd4);
        @(negedge Clk);
        A = 64'hDEAD_BEEF_0000_1111; B = 64'h5;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk);
            #1;
            chk("hold_done", {63'd0, Done}, 64'd1);
            chk("hold_sum", Sum, held);
        end
        release_done();
        chk("hold_sum_idle", Sum, held);
        run_op(64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, 1'b0, 1'b0, 1'b0, lat);
        chk("rerun_sum", Sum, 64'h1212_2323_3434_4545);
        release_done();

        // Reset during the third ADD cycle, with Run asserted (reset wins)
        @(negedge Clk);
        A = 64'hFFFF_FFFF_FFFF_FFFF; B = 64'h1; Sub = 1'b0; Run = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        chk("midrst_sum", Sum, 64'h0);
        chk("midrst_co", {63'd0, CO}, 64'd0);
        chk("midrst_done", {63'd0, Done}, 64'd0);
        @(negedge Clk);
        Reset = 1'b1; Run = 1'b0;
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk);
            #1;
            if (Done) lat++;
        end
        chk("rst_prio_no_run", 64'(lat), 64'd0);
        run_op(64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 1'b0, 1'b0, 1'b0, lat);
        chk("postrst_sum", Sum, 64'h7777_7777_7777_7777);
        chk("postrst_co", {63'd0, CO}, 64'd0);
        release_done();

`ifdef ADDER_SEQ_OVF_EN
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, lat);
        chk("ovf1_sum", Sum, 64'h8000_0000_0000_0000);
        chk("ovf1_v", {63'd0, V}, 64'd1);
        chk("ovf1_co", {63'd0, CO}, 64'd0);
        release_done();
        run_op(64'h8888_8888_8888_8888, 64'h8888_8888_8888_8888, 1'b0, 1'b0, 1'b0, lat);
        chk("ovf2_v", {63'd0, V}, 64'd1);
        chk("ovf2_co", {63'd0, CO}, 64'd1);
        release_done();
`endif

        // Random operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            logic [63:0] ra, rb;
            logic        rs, rt;
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            if (i % 5 == 0) rb = ra;
            rs = 1'($urandom_range(0, 1));
            rt = 1'($urandom_range(0, 1));
            model(ra, rb, rs, es, ec, ev);
            run_op(ra, rb, rs, rt, 1'b0, lat);
            chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'd4);
            chk($sformatf("rnd%0d_sum", i), Sum, es);
            chk($sformatf("rnd%0d_co", i), {63'd0, CO}, {63'd0, ec});
`ifdef ADDER_SEQ_OVF_EN
            chk($sformatf("rnd%0d_v", i), {63'd0, V}, {63'd0, ev});
`endif
            release_done();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/adder_sequencer.md
ADDER_SEQUENCER -- requirements
Module: adder_sequencer

Interface
REQ-001 SHALL have parameter SLICES, default 4: number of 16-bit slices; operand width W = 16*SLICES.
REQ-002 SHALL have port Clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port Reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port Run  input  1  start request, sampled only in IDLE.
REQ-005 SHALL have port Sub  input  1  0 = A+B, 1 = A-B; latched with the operands.
REQ-006 SHALL have port A  input  W  operand A.
REQ-007 SHALL have port B  input  W  operand B.
REQ-008 SHALL have port Sum  output  W  registered result.
REQ-009 SHALL have port CO  output  1  registered carry-out of the top slice (Sub=1: 1 = no borrow).
REQ-010 SHALL have port Done  output  1  result valid, registered.

Function
REQ-011 SHALL implement states IDLE, ADD, DONE with a slice counter idx of width clog2(SLICES).
REQ-012 In IDLE with Run=1 at a rising edge, SHALL latch A, B and Sub; clear Sum, CO and idx; set carry register to Sub; go to ADD.
REQ-013 In ADD, each edge SHALL write Sum[16*idx +: 16] = A_slice + (Sub ? ~B_slice : B_slice) + carry, store the slice carry-out, and increment idx.
REQ-014 When the slice with idx = SLICES-1 is written, the same edge SHALL load CO with that slice's carry-out and enter DONE.
REQ-015 Done SHALL be 1 only in DONE; latency from capture edge to Done=1 is exactly SLICES cycles (4 at default).
REQ-016 DONE SHALL hold while Run=1; the first edge with Run=0 SHALL return to IDLE (no auto-restart while Run is held).
REQ-017 Sum and CO SHALL hold their values in DONE and IDLE until the next capture.
REQ-018 Changes on Run, Sub, A or B during ADD SHALL NOT affect the operation in progress.
REQ-019 Arithmetic SHALL be modulo 2^W; carry chains between slices only through the carry register.

Reset
REQ-020 Reset=0 at a rising edge SHALL force IDLE, idx=0, carry=0, Sum=0, CO=0, Done=0, and clear the latched operands; this includes during ADD and DONE.
REQ-021 Reset SHALL take priority over Run on the same edge.

Configuration
REQ-022 With macro ADDER_SEQ_OVF_EN defined, SHALL add output V (1 bit): signed two's-complement overflow of the full W-bit operation, written on the same edge as CO, reset to 0, held like CO.
REQ-023 Without ADDER_SEQ_OVF_EN, port V and its logic SHALL NOT exist; all other behaviour is unchanged.

Structure
REQ-024 Package adder_seq_pkg SHALL hold SLICE_W = 16 and the state enum typedef (IDLE, ADD, DONE).
REQ-025 One 16-bit adder slice with carry-in/carry-out SHALL be a sub-module adder16_ci, instantiated once and reused every ADD cycle.

Verification (SLICES=4)
REQ-026 A=0x0000_0000_0000_FFFF, B=0x1, Sub=0, Run pulse -> Sum=0x0000_0000_0001_0000, CO=0, Done rises 4 cycles after capture.
REQ-027 A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, Sub=0 -> Sum=0, CO=1; then A=0x0, B=0x1, Sub=1 -> Sum=0xFFFF_FFFF_FFFF_FFFF, CO=0.
REQ-028 A=0x0000_0000_0001_0000, B=0x1, Sub=1 -> Sum=0x0000_0000_0000_FFFF, CO=1; A/B toggled during ADD do not change the result.
REQ-029 Run held high 10 cycles after Done -> Done stays 1, Sum unchanged, no restart; Run low then high -> new operation captured.
REQ-030 Reset=0 during the third ADD cycle -> next edge IDLE, Sum=0, CO=0, Done=0; subsequent 0x3333_3333_3333_3333 + 0x4444_4444_4444_4444 -> 0x7777_7777_7777_7777, CO=0.
REQ-031 With ADDER_SEQ_OVF_EN: A=0x7FFF_FFFF_FFFF_FFFF, B=0x1, Sub=0 -> Sum=0x8000_0000_0000_0000, V=1, CO=0; A=0x8888_8888_8888_8888 + same -> V=1, CO=1.
